song_sequencer: RTL and testbench

Note source for the guitar-hero datapath. It holds a small song memory of 4-lane note patterns with per-note durations and plays it back at a fixed tempo. During playback it drives `song_data`, which the points/scoring logic compares against `buttons`. It is the producer end of the `song_data` interface that the scoring block consumes.

---
 rtl/song_sequencer.sv | 179 +++++++++++++++++
 tb/tb_song_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/song_sequencer.sv
// ============================================================================
// Module   : song_sequencer
// Purpose  : Song memory and fixed-tempo playback of 4-lane note patterns.
// Revision : 1.0
// ============================================================================
`default_nettype none

module song_sequencer #(
   parameter int DEPTH    = 64,
   parameter int ADDR_W   = 6,
   parameter int TICK_DIV = 25_000_000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              pause,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [7:0]        wr_data,
   output logic [3:0]        song_data,
   output logic              note_start,
   output logic [ADDR_W-1:0] song_pos,
   output logic              playing,
   output logic              done
);

   localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   localparam logic [1:0] c_IDLE  = 2'd0;
   localparam logic [1:0] c_PLAY  = 2'd1;
   localparam logic [1:0] c_PAUSE = 2'd2;
   localparam logic [1:0] c_DONE  = 2'd3;

   localparam logic [TICK_W-1:0] c_TICK_LAST = TICK_W'(TICK_DIV - 1);
   localparam logic [ADDR_W-1:0] c_POS_LAST  = ADDR_W'(DEPTH - 1);

   logic [7:0]        r_mem [DEPTH];
   logic [1:0]        r_state;
   logic [1:0]        w_state_next;
   logic [TICK_W-1:0] r_tick;
   logic [3:0]        r_beat;
   logic [ADDR_W-1:0] r_pos;
   logic [3:0]        r_data;
   logic              r_note_start;

   logic              w_active;
   logic              w_tick_wrap;
   logic              w_note_end;
   logic [ADDR_W-1:0] w_pos_next;
   logic [7:0]        w_entry0;
   logic [7:0]        w_entry_next;
   logic              w_load;
   logic              w_stop;
   logic              w_restart;
   logic [ADDR_W-1:0] w_load_addr;
   logic [7:0]        w_load_entry;
   logic              w_wr_ok;

   assign w_wr_ok      = (r_state == c_IDLE) || (r_state == c_DONE);
   // PAUSE with pause low counts on that same edge, so both states advance alike
   assign w_active     = ((r_state == c_PLAY) || (r_state == c_PAUSE)) && !pause;
   assign w_tick_wrap  = (r_tick == c_TICK_LAST);
   assign w_note_end   = w_tick_wrap && (r_beat == 4'd0);
   assign w_pos_next   = r_pos + 1'b1;
   assign w_entry0     = r_mem[0];
   assign w_entry_next = r_mem[w_pos_next];

   always_ff @(posedge clk) begin
      if (wr_en && w_wr_ok) begin
         r_mem[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= c_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_load       = 1'b0;
      w_stop       = 1'b0;
      w_restart    = 1'b0;
      w_load_addr  = r_pos;
      w_load_entry = w_entry_next;
      case (r_state)
         c_IDLE, c_DONE: begin
            if (start) begin
               w_restart    = 1'b1;
               w_load_addr  = '0;
               w_load_entry = w_entry0;
               if (w_entry0[7:4] == 4'd0) begin
                  w_state_next = c_DONE;
                  w_stop       = 1'b1;
               end else begin
                  w_state_next = c_PLAY;
                  w_load       = 1'b1;
               end
            end
         end
         c_PLAY, c_PAUSE: begin
            if (pause) begin
               w_state_next = c_PAUSE;
            end else begin
               w_state_next = c_PLAY;
               if (w_note_end) begin
                  // No wrap-around: the last address always ends the song
                  if ((r_pos == c_POS_LAST) || (w_entry_next[7:4] == 4'd0)) begin
                     w_state_next = c_DONE;
                     w_stop       = 1'b1;
                  end else begin
                     w_load      = 1'b1;
                     w_load_addr = w_pos_next;
                  end
               end
            end
         end
         default: begin
            w_state_next = c_IDLE;
         end
      endcase
   end

   always_comb begin
      playing = 1'b0;
      done    = 1'b0;
      case (r_state)
         c_PLAY, c_PAUSE: playing = 1'b1;
         c_DONE:          done    = 1'b1;
         default: begin
            playing = 1'b0;
            done    = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_tick       <= '0;
         r_beat       <= 4'd0;
         r_pos        <= '0;
         r_data       <= 4'd0;
         r_note_start <= 1'b0;
      end else begin
         r_note_start <= 1'b0;
         if (w_load) begin
            r_pos        <= w_load_addr;
            r_data       <= w_load_entry[3:0];
            r_beat       <= w_load_entry[7:4] - 4'd1;
            r_tick       <= '0;
            r_note_start <= 1'b1;
         end else if (w_stop) begin
            r_data <= 4'd0;
            r_beat <= 4'd0;
            r_tick <= '0;
            if (w_restart) begin
               r_pos <= '0;
            end
         end else if (w_active) begin
            if (w_tick_wrap) begin
               r_tick <= '0;
               r_beat <= r_beat - 4'd1;
            end else begin
               r_tick <= r_tick + 1'b1;
            end
         end
      end
   end

   assign song_data  = r_data;
   assign note_start = r_note_start;
   assign song_pos   = r_pos;

endmodule

`default_nettype wire

// File: tb/tb_song_sequencer.sv
// ============================================================================
// Module   : tb_song_sequencer
// Purpose  : Scoreboard bench for song_sequencer (DEPTH=8, TICK_DIV=4).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_song_sequencer;

   localparam int DEPTH    = 8;
   localparam int ADDR_W   = 3;
   localparam int TICK_DIV = 4;

   typedef struct packed {
      logic [3:0] data;
      logic       ns;
      logic       play;
      logic       dn;
      logic [2:0] pos;
      logic       chk_pos;
   } rec_t;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              start = 1'b0;
   logic              pause = 1'b0;
   logic              wr_en = 1'b0;
   logic [ADDR_W-1:0] wr_addr = '0;
   logic [7:0]        wr_data = 8'h00;
   logic [3:0]        song_data;
   logic              note_start;
   logic [ADDR_W-1:0] song_pos;
   logic              playing;
   logic              done;

   rec_t       sb [$];
   logic [7:0] model_mem [DEPTH];
   int         n_checks = 0;
   int         n_fail   = 0;

   song_sequencer #(
      .DEPTH    (DEPTH),
      .ADDR_W   (ADDR_W),
      .TICK_DIV (TICK_DIV)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .pause      (pause),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .song_data  (song_data),
      .note_start (note_start),
      .song_pos   (song_pos),
      .playing    (playing),
      .done       (done)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, time=%0t required=finished", $time);
      $fatal(1);
   end

   task automatic mem_write(input logic [2:0] a, input logic [7:0] d);
      wr_en   = 1'b1;
      wr_addr = a;
      wr_data = d;
      model_mem[a] = d;
      @(posedge clk); #1;
      wr_en = 1'b0;
   endtask

   task automatic push_rec(input logic [3:0] d, input logic ns, input logic pl,
                           input logic dn, input logic [2:0] p, input logic chk);
      rec_t r;
      r.data = d; r.ns = ns; r.play = pl; r.dn = dn; r.pos = p; r.chk_pos = chk;
      sb.push_back(r);
   endtask

   // Expected per-cycle timeline of an uninterrupted playback of model_mem
   task automatic push_song(input logic chk_done_pos);
      int a = 0;
      int last = 0;
      forever begin
         int dur = int'(model_mem[a][7:4]);
         if (dur == 0) break;
         for (int k = 0; k < dur * TICK_DIV; k++)
            push_rec(model_mem[a][3:0], k == 0, 1'b1, 1'b0, 3'(a), 1'b1);
         last = a;
         if (a == DEPTH - 1) break;
         a++;
      end
      push_rec(4'h0, 1'b0, 1'b0, 1'b1, 3'(last), chk_done_pos);
   endtask

   task automatic test_reset();
      int c;
      rec_t e;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if ({song_data, note_start, song_pos, playing, done} !== 10'b0) begin
         n_fail++;
         $display("FAIL reset_state: data=%h ns=%b pos=%0d play=%b done=%b required all 0",
                  song_data, note_start, song_pos, playing, done);
      end
      reset = 1'b0;
      mem_write(3'd0, 8'h21);
      mem_write(3'd1, 8'h1A);
      mem_write(3'd2, 8'h00);
      push_song(1'b0);
      while (sb.size() > 5) void'(sb.pop_back());
      push_rec(4'h0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
      start = 1'b1;
      c = 0;
      while (sb.size() != 0) begin
         @(posedge clk); #1;
         e = sb.pop_front();
         n_checks++;
         if ({song_data, note_start, playing, done} !== {e.data, e.ns, e.play, e.dn} ||
             (e.chk_pos && song_pos !== e.pos)) begin
            n_fail++;
            $display("FAIL reset_mid_play c=%0d: got d=%h ns=%b pl=%b dn=%b pos=%0d required d=%h ns=%b pl=%b dn=%b pos=%0d",
                     c, song_data, note_start, playing, done, song_pos, e.data, e.ns, e.play, e.dn, e.pos);
         end
         if (c == 0) start = 1'b0;
         if (c == 4) reset = 1'b1;
         if (c == 5) reset = 1'b0;
         c++;
      end
      push_song(1'b0);
      start = 1'b1;
      c = 0;
      while (sb.size() != 0) begin
         @(posedge clk); #1;
         e = sb.pop_front();
         n_checks++;
         if ({song_data, note_start, playing, done} !== {e.data, e.ns, e.play, e.dn} ||
             (e.chk_pos && song_pos !== e.pos)) begin
            n_fail++;
            $display("FAIL replay_after_reset c=%0d: got d=%h ns=%b pl=%b dn=%b pos=%0d required d=%h ns=%b pl=%b dn=%b pos=%0d",
                     c, song_data, note_start, playing, done, song_pos, e.data, e.ns, e.play, e.dn, e.pos);
         end
         if (c == 0) start = 1'b0;
         c++;
      end
   endtask

   task automatic test_full_memory();
      int c;
      rec_t e;
      for (int i = 0; i < DEPTH; i++) mem_write(3'(i), 8'h1F);
      push_song(1'b1);
      push_rec(4'h0, 1'b0, 1'b0, 1'b1, 3'd7, 1'b1);
      start = 1'b1;
      c = 0;
      while (sb.size() != 0) begin
         @(posedge clk); #1;
         e = sb.pop_front();
         n_checks++;
         if ({song_data, note_start, playing, done} !== {e.data, e.ns, e.play, e.dn} ||
             (e.chk_pos && song_pos !== e.pos)) begin
            n_fail++;
            $display("FAIL full_memory c=%0d: got d=%h ns=%b pl=%b dn=%b pos=%0d required d=%h ns=%b pl=%b dn=%b pos=%0d",
                     c, song_data, note_start, playing, done, song_pos, e.data, e.ns, e.play, e.dn, e.pos);
         end
         if (c == 0) start = 1'b0;
         c++;
      end
   endtask

   task automatic test_pause();
      int c;
      rec_t e;
      mem_write(3'd0, 8'h33);
      mem_write(3'd1, 8'h00);
      for (int k = 0; k < 3; k++)  push_rec(4'h3, k == 0, 1'b1, 1'b0, 3'd0, 1'b1);
      for (int k = 0; k < 10; k++) push_rec(4'h3, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1);
      for (int k = 0; k < 9; k++)  push_rec(4'h3, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1);
      push_rec(4'h0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b1);
      start = 1'b1;
      c = 0;
      while (sb.size() != 0) begin
         @(posedge clk); #1;
         e = sb.pop_front();
         n_checks++;
         if ({song_data, note_start, playing, done} !== {e.data, e.ns, e.play, e.dn} ||
             (e.chk_pos && song_pos !== e.pos)) begin
            n_fail++;
            $display("FAIL pause_mid_note c=%0d: got d=%h ns=%b pl=%b dn=%b pos=%0d required d=%h ns=%b pl=%b dn=%b pos=%0d",
                     c, song_data, note_start, playing, done, song_pos, e.data, e.ns, e.play, e.dn, e.pos);
         end
         if (c == 0)  start = 1'b0;
         if (c == 2)  pause = 1'b1;
         if (c == 12) pause = 1'b0;
         c++;
      end
   endtask

   task automatic test_pause_at_note_end();
      int c;
      rec_t e;
      mem_write(3'd0, 8'h11);
      mem_write(3'd1, 8'h12);
      mem_write(3'd2, 8'h00);
      for (int k = 0; k < 7; k++) push_rec(4'h1, k == 0, 1'b1, 1'b0, 3'd0, 1'b1);
      for (int k = 0; k < 4; k++) push_rec(4'h2, k == 0, 1'b1, 1'b0, 3'd1, 1'b1);
      push_rec(4'h0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0);
      start = 1'b1;
      c = 0;
      while (sb.size() != 0) begin
         @(posedge clk); #1;
         e = sb.pop_front();
         n_checks++;
         if ({song_data, note_start, playing, done} !== {e.data, e.ns, e.play, e.dn} ||
             (e.chk_pos && song_pos !== e.pos)) begin
            n_fail++;
            $display("FAIL pause_note_end c=%0d: got d=%h ns=%b pl=%b dn=%b pos=%0d required d=%h ns=%b pl=%b dn=%b pos=%0d",
                     c, song_data, note_start, playing, done, song_pos, e.data, e.ns, e.play, e.dn, e.pos);
         end
         if (c == 0) start = 1'b0;
         if (c == 3) pause = 1'b1;
         if (c == 6) pause = 1'b0;
         c++;
      end
   endtask

   task automatic test_guards();
      int c;
      rec_t e;
      mem_write(3'd0, 8'h21);
      mem_write(3'd1, 8'h1A);
      mem_write(3'd2, 8'h00);
      push_song(1'b0);
      start = 1'b1;
      c = 0;
      while (sb.size() != 0) begin
         @(posedge clk); #1;
         e = sb.pop_front();
         n_checks++;
         if ({song_data, note_start, playing, done} !== {e.data, e.ns, e.play, e.dn} ||
             (e.chk_pos && song_pos !== e.pos)) begin
            n_fail++;
            $display("FAIL guard_in_play c=%0d: got d=%h ns=%b pl=%b dn=%b pos=%0d required d=%h ns=%b pl=%b dn=%b pos=%0d",
                     c, song_data, note_start, playing, done, song_pos, e.data, e.ns, e.play, e.dn, e.pos);
         end
         if (c == 0) start = 1'b0;
         if (c == 2) begin wr_en = 1'b1; wr_addr = 3'd1; wr_data = 8'h5F; end
         if (c == 3) wr_en = 1'b0;
         if (c == 4) start = 1'b1;
         if (c == 5) start = 1'b0;
         c++;
      end
      mem_write(3'd1, 8'h5F);
      push_song(1'b0);
      start = 1'b1;
      c = 0;
      while (sb.size() != 0) begin
         @(posedge clk); #1;
         e = sb.pop_front();
         n_checks++;
         if ({song_data, note_start, playing, done} !== {e.data, e.ns, e.play, e.dn} ||
             (e.chk_pos && song_pos !== e.pos)) begin
            n_fail++;
            $display("FAIL guard_write_in_done c=%0d: got d=%h ns=%b pl=%b dn=%b pos=%0d required d=%h ns=%b pl=%b dn=%b pos=%0d",
                     c, song_data, note_start, playing, done, song_pos, e.data, e.ns, e.play, e.dn, e.pos);
         end
         if (c == 0) start = 1'b0;
         c++;
      end
   endtask

   task automatic test_zero_first();
      int c;
      rec_t e;
      mem_write(3'd0, 8'h07);
      push_rec(4'h0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0);
      push_rec(4'h0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0);
      push_rec(4'h0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0);
      start = 1'b1;
      c = 0;
      while (sb.size() != 0) begin
         @(posedge clk); #1;
         e = sb.pop_front();
         n_checks++;
         if ({song_data, note_start, playing, done} !== {e.data, e.ns, e.play, e.dn} ||
             (e.chk_pos && song_pos !== e.pos)) begin
            n_fail++;
            $display("FAIL zero_first c=%0d: got d=%h ns=%b pl=%b dn=%b pos=%0d required d=%h ns=%b pl=%b dn=%b pos=%0d",
                     c, song_data, note_start, playing, done, song_pos, e.data, e.ns, e.play, e.dn, e.pos);
         end
         if (c == 0) start = 1'b0;
         c++;
      end
   endtask

   initial begin
      test_reset();
      test_full_memory();
      test_pause();
      test_pause_at_note_end();
      test_guards();
      test_zero_first();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
